// File: rtl/usermem_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usermem_timer: memory-mapped prescaled down-counter with CPU interrupt.      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module usermem_timer #(
    parameter logic [7:0] BASE = 8'hF8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uaddr,
    inout  wire  [7:0] udata,
    input  logic       rw,
    output logic       sel,
    output logic       interrupt
);

    localparam logic [2:0] C_OFF_CTRL     = 3'd0;
    localparam logic [2:0] C_OFF_STATUS   = 3'd1;
    localparam logic [2:0] C_OFF_RELOAD   = 3'd2;
    localparam logic [2:0] C_OFF_COUNT    = 3'd3;
    localparam logic [2:0] C_OFF_PRESCALE = 3'd4;

    logic       en_q, en_d;
    logic       auto_q, auto_d;
    logic       ie_q, ie_d;
    logic       exp_q, exp_d;
    logic       irq_q, irq_d;
    logic [7:0] reload_q, reload_d;
    logic [7:0] count_q, count_d;
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] psc_q, psc_d;

    logic       w_wr_en;
    logic       w_tick;
    logic       w_expire;
    logic [7:0] w_rdata;

    assign sel       = (uaddr[7:3] == BASE[7:3]);
    assign w_wr_en   = sel && rw;
    assign interrupt = irq_q;

    always_comb begin
        w_rdata = 8'h00;
        case (uaddr[2:0])
            C_OFF_CTRL:     w_rdata = {5'b0, ie_q, auto_q, en_q};
            C_OFF_STATUS:   w_rdata = {6'b0, en_q, exp_q};
            C_OFF_RELOAD:   w_rdata = reload_q;
            C_OFF_COUNT:    w_rdata = count_q;
            C_OFF_PRESCALE: w_rdata = prescale_q;
            default:        w_rdata = 8'h00;
        endcase
    end

    assign udata = (sel && !rw) ? w_rdata : 8'bz;

    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        exp_d      = exp_q;
        reload_d   = reload_q;
        count_d    = count_q;
        prescale_d = prescale_q;
        psc_d      = psc_q;
        irq_d      = 1'b0;

        w_tick   = en_q && (psc_q == prescale_q);
        w_expire = w_tick && (count_q == 8'd0);

        if (en_q) begin
            psc_d = w_tick ? 8'd0 : psc_q + 8'd1;
        end

        // Timer action first; bus writes below override it where they collide.
        if (w_tick) begin
            if (count_q != 8'd0) begin
                count_d = count_q - 8'd1;
            end else begin
                irq_d = ie_q;
                if (auto_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (w_wr_en) begin
            case (uaddr[2:0])
                C_OFF_CTRL: begin
                    en_d   = udata[0];
                    auto_d = udata[1];
                    ie_d   = udata[2];
                    if (udata[0] && !en_q) begin
                        psc_d = 8'd0;
                    end
                end
                C_OFF_STATUS: begin
                    if (udata[0]) begin
                        exp_d = 1'b0;
                    end
                end
                C_OFF_RELOAD:   reload_d = udata;
                C_OFF_COUNT: begin
                    count_d = udata;
                    psc_d   = 8'd0;
                end
                C_OFF_PRESCALE: prescale_d = udata;
                default: ;
            endcase
        end

        // A same-cycle expiry must not be lost to a W1C clear.
        if (w_expire) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            exp_q      <= 1'b0;
            irq_q      <= 1'b0;
            reload_q   <= 8'd0;
            count_q    <= 8'd0;
            prescale_q <= 8'd0;
            psc_q      <= 8'd0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            exp_q      <= exp_d;
            irq_q      <= irq_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usermem_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usermem_timer: directed and randomized bench for usermem_timer.           |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_usermem_timer;

    logic       clk = 1'b1;
    logic       reset;
    logic [7:0] uaddr;
    logic       rw;
    logic       sel;
    logic       interrupt;
    logic [7:0] drv;
    logic       drv_en;
    wire  [7:0] udata;

    int total = 0;
    int bad   = 0;

    assign udata = drv_en ? drv : 8'bz;

    // Weak pull-ups make an undriven bus read back as FF.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pu
            pullup pu (udata[gi]);
        end
    endgenerate

    always #5 clk = ~clk;

    usermem_timer #(.BASE(8'hF8)) dut (
        .clk       (clk),
        .reset     (reset),
        .uaddr     (uaddr),
        .udata     (udata),
        .rw        (rw),
        .sel       (sel),
        .interrupt (interrupt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        uaddr  = a;
        drv    = d;
        drv_en = 1'b1;
        rw     = 1'b1;
        @(negedge clk);
        #1;
        drv_en = 1'b0;
        rw     = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        uaddr = a;
        rw    = 1'b0;
        #1;
        d = udata;
    endtask

    task automatic chk_irq(input string tag, input bit expv);
        check(tag, {7'b0, interrupt}, {7'b0, expv});
    endtask

    // Closed-form model of an auto-reload run started by CTRL=07 at t=0:
    // ticks land on multiples of p+1, the first expiry is tick n+1, later
    // expiries every r+1 ticks, and COUNT reads back from those tick counts.
    task automatic run_auto(input int n, input int r, input int p, input string tag);
        logic [7:0] v;
        int T;
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'(p));
        wr(8'hFA, 8'(r));
        wr(8'hFB, 8'(n));
        wr(8'hF8, 8'h07);
        chk_irq({tag, "_irq_t0"}, 1'b0);
        rd(8'hFB, v);
        check({tag, "_cnt_t0"}, v, 8'(n));
        T = (n + 1 + 2 * (r + 1)) * (p + 1) + 1;
        for (int t = 1; t <= T; t++) begin
            int k;
            bit e_irq;
            int e_cnt;
            step();
            k     = t / (p + 1);
            e_irq = 1'b0;
            if (k <= n) begin
                e_cnt = n - k;
            end else begin
                e_cnt = r - ((k - n - 1) % (r + 1));
                if ((t % (p + 1)) == 0 && ((k - n - 1) % (r + 1)) == 0) e_irq = 1'b1;
            end
            chk_irq({tag, "_irq"}, e_irq);
            rd(8'hFB, v);
            check({tag, "_cnt"}, v, 8'(e_cnt));
        end
    endtask

    initial begin
        logic [7:0] v;
        bit found;

        reset  = 1'b0;
        rw     = 1'b0;
        uaddr  = 8'h00;
        drv    = 8'h00;
        drv_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_irq("reset_irq", 1'b0);
        @(posedge clk);
        reset = 1'b1;
        #1;

        // Reset values and address decode
        for (int a = 8'hF8; a <= 8'hFF; a++) begin
            rd(8'(a), v);
            check("map_sel", {7'b0, sel}, 8'h01);
            check("map_rd", v, 8'h00);
        end
        rd(8'hF7, v);
        check("sel_f7", {7'b0, sel}, 8'h00);
        rd(8'h00, v);
        check("sel_00", {7'b0, sel}, 8'h00);
        check("hiz_00", v, 8'hFF);

        // Auto-reload, PRESCALE=0, RELOAD=3, COUNT=3
        run_auto(3, 3, 0, "auto");

        // One-shot with prescaler: pulse 6 clocks after CTRL write
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'h01);
        wr(8'hFB, 8'h02);
        wr(8'hF8, 8'h05);
        for (int t = 1; t <= 10; t++) begin
            step();
            chk_irq("oneshot_irq", (t == 6));
        end
        rd(8'hF8, v); check("oneshot_ctrl", v, 8'h04);
        rd(8'hF9, v); check("oneshot_status", v, 8'h01);
        rd(8'hFB, v); check("oneshot_count", v, 8'h00);

        // W1C and masked expiry
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'h00);
        wr(8'hFB, 8'h00);
        wr(8'hF8, 8'h01);
        step();
        chk_irq("masked_irq1", 1'b0);
        step();
        chk_irq("masked_irq2", 1'b0);
        rd(8'hF9, v); check("masked_exp", v, 8'h01);
        wr(8'hF9, 8'h00);
        rd(8'hF9, v); check("w1c_zero_keeps", v, 8'h01);
        wr(8'hF9, 8'h01);
        rd(8'hF9, v); check("w1c_clears", v, 8'h00);
        wr(8'hFB, 8'h00);
        wr(8'hF8, 8'h01);
        wr(8'hF9, 8'h01);
        rd(8'hF9, v); check("w1c_vs_expiry", v, 8'h01);
        wr(8'hF8, 8'h04);
        chk_irq("no_retro_irq0", 1'b0);
        step();
        chk_irq("no_retro_irq1", 1'b0);

        // COUNT write mid-run
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'h00);
        wr(8'hFA, 8'd10);
        wr(8'hFB, 8'd10);
        wr(8'hF8, 8'h07);
        repeat (3) step();
        wr(8'hFB, 8'h05);
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t == 1) begin
                rd(8'hFB, v);
                check("midwr_next", v, 8'h04);
            end
            chk_irq("midwr_irq", (t == 6));
        end

        // Randomized auto-reload runs
        for (int it = 0; it < 4; it++) begin
            run_auto(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 2)), "rand");
        end

        // PRESCALE=FF divides by 256
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'hFF);
        wr(8'hFB, 8'h00);
        wr(8'hF8, 8'h05);
        repeat (255) step();
        chk_irq("div256_before", 1'b0);
        step();
        chk_irq("div256_at", 1'b1);
        step();
        chk_irq("div256_after", 1'b0);

        // Async reset while interrupt is high
        wr(8'hF8, 8'h00);
        wr(8'hF9, 8'h01);
        wr(8'hFC, 8'h00);
        wr(8'hFA, 8'h03);
        wr(8'hFB, 8'h03);
        wr(8'hF8, 8'h07);
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            step();
            if (interrupt === 1'b1) found = 1'b1;
        end
        check("arst_irq_seen", {7'b0, found}, 8'h01);
        #1;
        reset = 1'b0;
        #1;
        chk_irq("arst_irq_now", 1'b0);
        rd(8'hF8, v); check("arst_ctrl", v, 8'h00);
        rd(8'hF9, v); check("arst_status", v, 8'h00);
        rd(8'hFA, v); check("arst_reload", v, 8'h00);
        rd(8'hFB, v); check("arst_count", v, 8'h00);
        @(posedge clk);
        reset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            chk_irq("arst_no_pulse", 1'b0);
        end
        rd(8'hFB, v); check("arst_count_hold", v, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
